csa_multiword_add_ctrl: RTL
===========================

Name: csa_multiword_add_ctrl

Overview:
Sequencer that performs a WIDTH-bit add/subtract by time-multiplexing one shared 16-bit carry_select_adder_4x4 over WIDTH/16 clock cycles, least-significant slice first. The inter-slice carry is held in a register. Sits between a requesting datapath (start/done handshake) and the existing 16-bit carry select adder, which it instantiates. Lets wide arithmetic reuse the 16-bit adder instead of replicating it.

Parameters:
WIDTH, 64, operand/result width; must be a multiple of 16 and at least 16.
NSLICES, WIDTH/16, derived local parameter; number of adder passes. Not overridable.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request pulse; sampled only in IDLE.
op_sub  input  1  0 = a + b + c_in; 1 = a - b (c_in ignored).
c_in  input  1  carry-in for add.
a  input  WIDTH  operand A; captured when start is accepted.
b  input  WIDTH  operand B; captured when start is accepted.
busy  output  1  high while an operation is in progress.
done  output  1  single-cycle completion pulse.
s  output  WIDTH  registered result.
c_out  output  1  final carry. For subtract, 1 means no borrow (a >= b unsigned).

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy=0, done=0, s=0, c_out=0; operand, carry and slice-index registers = 0. Reset asserted mid-operation aborts it: no done pulse, partial result discarded.
- States: IDLE, RUN.
- IDLE:
  - On a rising edge with start=1, capture a into the A register.
  - Capture b into the B register, or ~b if op_sub=1.
  - Carry register <= (op_sub ? 1 : c_in).
  - Slice index <= 0; busy <= 1; go to RUN.
  - s and c_out keep their previous values until overwritten.
- RUN, one slice per cycle:
  - Adder inputs are A[16k+15:16k], B[16k+15:16k] and the carry register, where k = slice index.
  - Each edge writes the adder sum into s[16k+15:16k] and the adder carry into the carry register. Slice index increments.
  - On the edge that writes slice NSLICES-1: c_out <= adder carry; done <= 1; busy <= 0; go to IDLE.
- Timing: let E0 be the edge that accepts start.
  - busy is high after E0 through edge E(NSLICES), i.e. for exactly NSLICES cycles.
  - done is high for exactly one cycle after E(NSLICES).
  - s and c_out are final and valid in the done cycle. They then hold until the next accepted start overwrites them slice by slice.
- done is cleared on every edge where it is not being set.
- start while busy=1 is ignored: not queued, inputs not captured.
- start in the cycle where done=1 is accepted, since the state is already IDLE. Back-to-back throughput is one result per NSLICES+1 cycles.
- a, b, op_sub and c_in may change freely after acceptance; they have no effect until the next accept.
- Arithmetic is modulo 2^WIDTH. Carry ripples across slices through the carry register only.
- WIDTH=16: NSLICES=1, so done follows one edge after accept.

Test Plan:
- Reset with rst_n=0, any inputs -> busy=0, done=0, s=0, c_out=0; after release and no start, outputs stay 0.
- WIDTH=64, add, a=64'h0000_0000_0000_FFFF, b=64'h1, c_in=0 -> busy high 4 cycles; done one cycle after 4th edge; s=64'h0000_0000_0001_0000, c_out=0.
- Add, a=64'hFFFF_FFFF_FFFF_FFFF, b=64'h0, c_in=1 -> s=64'h0, c_out=1 (carry propagates through all 4 slices).
- Subtract, op_sub=1, a=64'd5, b=64'd7, c_in=1 -> s=64'hFFFF_FFFF_FFFF_FFFE, c_out=0. Then a=64'd7, b=64'd5 -> s=64'd2, c_out=1.
- Start pulsed during RUN with different operands -> ignored; first result unchanged. Start held high in the done cycle -> new op accepted immediately, busy high next cycle, second result correct.
- rst_n driven low after the 2nd RUN edge of an add -> all outputs 0 immediately; no done pulse. After release, a fresh start yields a correct result.

Source files
------------

// File: rtl/csa_multiword_add_ctrl.sv
// rtl/csa_multiword_add_ctrl.sv - WIDTH-bit add/sub sequenced over one shared 16-bit carry select adder
module carry_select_adder_4x4 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        c_in,
    output logic [15:0] s,
    output logic        c_out
);
    logic [4:0] chain;

    assign chain[0] = c_in;

    // Each nibble precomputes both carry-in outcomes; the incoming carry only drives a mux.
    for (genvar g = 0; g < 4; g++) begin : g_blk
        logic [4:0] sum0;
        logic [4:0] sum1;
        assign sum0           = {1'b0, a[4*g +: 4]} + {1'b0, b[4*g +: 4]};
        assign sum1           = sum0 + 5'd1;
        assign s[4*g +: 4]    = chain[g] ? sum1[3:0] : sum0[3:0];
        assign chain[g+1]     = chain[g] ? sum1[4]   : sum0[4];
    end

    assign c_out = chain[4];
endmodule

module csa_multiword_add_ctrl #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_sub,
    input  logic             c_in,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             c_out
);
    localparam int NSLICES = WIDTH / 16;
    localparam int IDX_W   = (NSLICES > 1) ? $clog2(NSLICES) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic               carry;
    logic [IDX_W-1:0]   idx;
    logic               last;
    logic [15:0]        slice_sum;
    logic               slice_carry;

    assign last = (idx == IDX_W'(NSLICES - 1));

    carry_select_adder_4x4 u_adder (
        .a     (a_reg[16*idx +: 16]),
        .b     (b_reg[16*idx +: 16]),
        .c_in  (carry),
        .s     (slice_sum),
        .c_out (slice_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = RUN;
            RUN:  if (last)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
            carry <= 1'b0;
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            s     <= '0;
            c_out <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        // Subtract is a + ~b + 1, so the inversion and the +1 are folded in here.
                        a_reg <= a;
                        b_reg <= op_sub ? ~b : b;
                        carry <= op_sub | c_in;
                        idx   <= '0;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    s[16*idx +: 16] <= slice_sum;
                    carry           <= slice_carry;
                    idx             <= idx + IDX_W'(1);
                    if (last) begin
                        c_out <= slice_carry;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
